// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot/run sequencer.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        StLoad,
        StDrain,
        StRelease,
        StRun,
        StHalt
    } boot_state_t;

    localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;
    localparam logic [31:0] EXIT_CODE     = 32'd10;
    localparam logic [4:0]  V0_REG        = 5'd2;

endpackage

// File: rtl/mips_boot_ctrl_if.sv
// Boot ROM, imem write port and core control/status bundle of the boot sequencer.
interface mips_boot_ctrl_if #(
    parameter int unsigned ROM_AW  = 6,
    parameter int unsigned IMEM_AW = 10
);
    logic [ROM_AW-1:0]  rom_addr;
    logic [31:0]        rom_data;
    logic               imem_wr_en;
    logic [IMEM_AW-1:0] imem_wr_addr;
    logic [31:0]        imem_wr_data;
    logic               cpu_reset;
    logic               cpu_run;
    logic [31:0]        instr;
    logic [31:0]        v0_val;
    logic               boot_done;
    logic               halted;
    logic               timeout;
    logic [31:0]        cycle_count;

    modport master (
        output rom_addr, imem_wr_en, imem_wr_addr, imem_wr_data,
        output cpu_reset, cpu_run, boot_done, halted, timeout, cycle_count,
        input  rom_data, instr, v0_val
    );

    modport slave (
        input  rom_addr, imem_wr_en, imem_wr_addr, imem_wr_data,
        input  cpu_reset, cpu_run, boot_done, halted, timeout, cycle_count,
        output rom_data, instr, v0_val
    );

endinterface

// File: rtl/mips_boot_ctrl_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_en && (r_count != '1)) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot sequencer: copies the boot ROM into imem with the core held in reset, then
// gates core execution and stops it on the exit syscall or when the cycle budget runs out.
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int unsigned BOOT_WORDS = 16,
    parameter int unsigned ROM_AW     = 6,
    parameter int unsigned IMEM_AW    = 10,
    parameter int unsigned BOOT_BASE  = 0,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input logic              clk,
    input logic              reset,
    mips_boot_ctrl_if.master bus
);

    localparam logic [ROM_AW-1:0]  LastAddr    = ROM_AW'(BOOT_WORDS - 1);
    localparam logic [IMEM_AW-1:0] BaseAddr    = IMEM_AW'(BOOT_BASE);
    localparam logic [31:0]        CountHitVal = MAX_CYCLES - 32'd1;

    boot_state_t        r_state, w_state_next;
    logic [ROM_AW-1:0]  r_rom_addr, w_rom_addr_next;
    logic               r_wr_en, w_wr_en_next;
    logic [IMEM_AW-1:0] r_wr_addr, w_wr_addr_next;
    logic               r_cpu_reset, w_cpu_reset_next;
    logic               r_cpu_run, w_cpu_run_next;
    logic               r_boot_done, w_boot_done_next;
    logic               r_halted, w_halted_next;
    logic               r_timeout, w_timeout_next;

    logic [31:0] w_count;
    logic        w_exit;
    logic        w_budget_hit;

    assign w_exit = (r_state == StRun) && (bus.instr == SYSCALL_INSTR) &&
                    (bus.v0_val == EXIT_CODE);
    // This RUN cycle's increment is the one that reaches the budget.
    assign w_budget_hit = (r_state == StRun) && (w_count == CountHitVal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:    if (r_rom_addr == LastAddr) w_state_next = StDrain;
            StDrain:   w_state_next = StRelease;
            StRelease: w_state_next = StRun;
            StRun:     if (w_exit || w_budget_hit) w_state_next = StHalt;
            StHalt:    w_state_next = StHalt;
            default:   w_state_next = StLoad;
        endcase
    end

    always_comb begin
        w_rom_addr_next  = r_rom_addr;
        w_wr_en_next     = (r_state == StLoad);
        w_wr_addr_next   = r_wr_addr;
        w_cpu_reset_next = (w_state_next == StLoad) || (w_state_next == StDrain);
        w_cpu_run_next   = (w_state_next == StRun);
        w_boot_done_next = (w_state_next == StRun) || (w_state_next == StHalt);
        w_halted_next    = (w_state_next == StHalt);
        // Exit wins over a coincident budget hit.
        w_timeout_next   = r_timeout || (w_budget_hit && !w_exit);
        if (r_state == StLoad) begin
            w_wr_addr_next = BaseAddr + IMEM_AW'(r_rom_addr);
            if (r_rom_addr != LastAddr) begin
                w_rom_addr_next = r_rom_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rom_addr  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_cpu_reset <= 1'b1;
            r_cpu_run   <= 1'b0;
            r_boot_done <= 1'b0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_rom_addr  <= w_rom_addr_next;
            r_wr_en     <= w_wr_en_next;
            r_wr_addr   <= w_wr_addr_next;
            r_cpu_reset <= w_cpu_reset_next;
            r_cpu_run   <= w_cpu_run_next;
            r_boot_done <= w_boot_done_next;
            r_halted    <= w_halted_next;
            r_timeout   <= w_timeout_next;
        end
    end

    sat_counter #(
        .WIDTH (32)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (r_state == StRun),
        .i_clr   (r_state == StLoad),
        .o_count (w_count)
    );

    assign bus.rom_addr     = r_rom_addr;
    assign bus.imem_wr_en   = r_wr_en;
    assign bus.imem_wr_addr = r_wr_addr;
    // The ROM output register already holds this word; gating keeps it 0 when idle.
    assign bus.imem_wr_data = r_wr_en ? bus.rom_data : 32'd0;
    assign bus.cpu_reset    = r_cpu_reset;
    assign bus.cpu_run      = r_cpu_run;
    assign bus.boot_done    = r_boot_done;
    assign bus.halted       = r_halted;
    assign bus.timeout      = r_timeout;
    assign bus.cycle_count  = w_count;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed bench: five sequencer configurations share one clock and reset timeline.
module tb_mips_boot_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_boot_ctrl_if #(.ROM_AW(6), .IMEM_AW(10)) if_a ();
    mips_boot_ctrl_if #(.ROM_AW(6), .IMEM_AW(10)) if_b ();
    mips_boot_ctrl_if #(.ROM_AW(6), .IMEM_AW(10)) if_c ();
    mips_boot_ctrl_if #(.ROM_AW(6), .IMEM_AW(10)) if_d ();
    mips_boot_ctrl_if #(.ROM_AW(6), .IMEM_AW(4))  if_e ();

    mips_boot_ctrl #(.BOOT_WORDS(4), .BOOT_BASE(8), .MAX_CYCLES(32'd100000))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    mips_boot_ctrl #(.BOOT_WORDS(4), .BOOT_BASE(0), .MAX_CYCLES(32'd5))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    mips_boot_ctrl #(.BOOT_WORDS(4), .BOOT_BASE(0), .MAX_CYCLES(32'd5))
        u_c (.clk(clk), .reset(reset), .bus(if_c));
    mips_boot_ctrl #(.BOOT_WORDS(1), .BOOT_BASE(0), .MAX_CYCLES(32'd100000))
        u_d (.clk(clk), .reset(reset), .bus(if_d));
    mips_boot_ctrl #(.BOOT_WORDS(2), .IMEM_AW(4), .BOOT_BASE(15), .MAX_CYCLES(32'd100000))
        u_e (.clk(clk), .reset(reset), .bus(if_e));

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        return 32'hA000_0000 | {26'd0, a};
    endfunction

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        if_a.rom_data <= rom_word(if_a.rom_addr);
        if_b.rom_data <= rom_word(if_b.rom_addr);
        if_c.rom_data <= rom_word(if_c.rom_addr);
        if_d.rom_data <= rom_word(if_d.rom_addr);
        if_e.rom_data <= rom_word(if_e.rom_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        reset    = 1'b1;
        if_a.instr = '0; if_a.v0_val = '0;
        if_b.instr = '0; if_b.v0_val = '0;
        if_c.instr = '0; if_c.v0_val = '0;
        if_d.instr = '0; if_d.v0_val = '0;
        if_e.instr = '0; if_e.v0_val = '0;

        repeat (2) step();
        check_eq("rst_rom_addr",  32'(if_a.rom_addr), 32'd0);
        check_eq("rst_wr_en",     32'(if_a.imem_wr_en), 32'd0);
        check_eq("rst_wr_addr",   32'(if_a.imem_wr_addr), 32'd0);
        check_eq("rst_wr_data",   if_a.imem_wr_data, 32'd0);
        check_eq("rst_cpu_reset", 32'(if_a.cpu_reset), 32'd1);
        check_eq("rst_cpu_run",   32'(if_a.cpu_run), 32'd0);
        check_eq("rst_boot_done", 32'(if_a.boot_done), 32'd0);
        check_eq("rst_halted",    32'(if_a.halted), 32'd0);
        check_eq("rst_timeout",   32'(if_a.timeout), 32'd0);
        check_eq("rst_count",     if_a.cycle_count, 32'd0);

        // Partial load, then reset asserted mid-LOAD at c = 2.
        reset = 1'b0;
        step();
        step();
        check_eq("pre_mid_wr_en",   32'(if_a.imem_wr_en), 32'd1);
        check_eq("pre_mid_wr_addr", 32'(if_a.imem_wr_addr), 32'd9);
        reset = 1'b1;
        #1;
        check_eq("mid_rom_addr",  32'(if_a.rom_addr), 32'd0);
        check_eq("mid_wr_en",     32'(if_a.imem_wr_en), 32'd0);
        check_eq("mid_wr_addr",   32'(if_a.imem_wr_addr), 32'd0);
        check_eq("mid_cpu_reset", 32'(if_a.cpu_reset), 32'd1);
        step();
        reset = 1'b0;

        for (int c = 0; c <= 16; c++) begin
            if_a.instr  = (c == 3 || c == 8 || c == 12) ? 32'h0000_000C : 32'd0;
            if_a.v0_val = (c == 8) ? 32'd4 : ((c == 3 || c == 12) ? 32'd10 : 32'd0);
            if_c.instr  = (c == 10) ? 32'h0000_000C : 32'd0;
            if_c.v0_val = (c == 10) ? 32'd10 : 32'd0;

            if (c >= 1 && c <= 4) begin
                check_eq($sformatf("a_wr_en_c%0d", c), 32'(if_a.imem_wr_en), 32'd1);
                check_eq($sformatf("a_wr_addr_c%0d", c), 32'(if_a.imem_wr_addr), 32'(8 + c - 1));
                check_eq($sformatf("a_wr_data_c%0d", c), if_a.imem_wr_data,
                         32'hA000_0000 + 32'(c - 1));
            end
            if (c <= 3) begin
                check_eq($sformatf("a_rom_addr_c%0d", c), 32'(if_a.rom_addr), 32'(c));
            end

            case (c)
                0: begin
                    check_eq("a_wr_en_c0", 32'(if_a.imem_wr_en), 32'd0);
                    check_eq("a_cpu_reset_c0", 32'(if_a.cpu_reset), 32'd1);
                end
                1: begin
                    check_eq("d_wr_en_c1", 32'(if_d.imem_wr_en), 32'd1);
                    check_eq("d_wr_addr_c1", 32'(if_d.imem_wr_addr), 32'd0);
                    check_eq("d_wr_data_c1", if_d.imem_wr_data, 32'hA000_0000);
                    check_eq("e_wr_addr_c1", 32'(if_e.imem_wr_addr), 32'd15);
                end
                2: begin
                    check_eq("d_wr_en_c2", 32'(if_d.imem_wr_en), 32'd0);
                    check_eq("d_cpu_reset_c2", 32'(if_d.cpu_reset), 32'd0);
                    check_eq("d_cpu_run_c2", 32'(if_d.cpu_run), 32'd0);
                    check_eq("e_wr_en_c2", 32'(if_e.imem_wr_en), 32'd1);
                    check_eq("e_wr_addr_c2", 32'(if_e.imem_wr_addr), 32'd0);
                    check_eq("e_wr_data_c2", if_e.imem_wr_data, 32'hA000_0001);
                end
                3: begin
                    check_eq("d_cpu_run_c3", 32'(if_d.cpu_run), 32'd1);
                    check_eq("e_wr_en_c3", 32'(if_e.imem_wr_en), 32'd0);
                end
                4: check_eq("a_cpu_reset_c4", 32'(if_a.cpu_reset), 32'd1);
                5: begin
                    check_eq("a_wr_en_c5", 32'(if_a.imem_wr_en), 32'd0);
                    check_eq("a_cpu_reset_c5", 32'(if_a.cpu_reset), 32'd0);
                    check_eq("a_cpu_run_c5", 32'(if_a.cpu_run), 32'd0);
                    check_eq("a_boot_done_c5", 32'(if_a.boot_done), 32'd0);
                end
                6: begin
                    check_eq("a_cpu_run_c6", 32'(if_a.cpu_run), 32'd1);
                    check_eq("a_boot_done_c6", 32'(if_a.boot_done), 32'd1);
                    check_eq("a_count_c6", if_a.cycle_count, 32'd0);
                end
                9: begin
                    check_eq("a_run_v0_4", 32'(if_a.cpu_run), 32'd1);
                    check_eq("a_halted_v0_4", 32'(if_a.halted), 32'd0);
                end
                10: begin
                    check_eq("b_halted_c10", 32'(if_b.halted), 32'd0);
                    check_eq("b_count_c10", if_b.cycle_count, 32'd4);
                end
                11: begin
                    check_eq("b_halted", 32'(if_b.halted), 32'd1);
                    check_eq("b_timeout", 32'(if_b.timeout), 32'd1);
                    check_eq("b_count", if_b.cycle_count, 32'd5);
                    check_eq("b_cpu_run", 32'(if_b.cpu_run), 32'd0);
                    check_eq("c_halted", 32'(if_c.halted), 32'd1);
                    check_eq("c_timeout", 32'(if_c.timeout), 32'd0);
                    check_eq("c_count", if_c.cycle_count, 32'd5);
                end
                12: begin
                    check_eq("a_count_c12", if_a.cycle_count, 32'd6);
                    check_eq("a_cpu_run_c12", 32'(if_a.cpu_run), 32'd1);
                end
                13: begin
                    check_eq("a_exit_count", if_a.cycle_count, 32'd7);
                    check_eq("a_exit_halted", 32'(if_a.halted), 32'd1);
                    check_eq("a_exit_timeout", 32'(if_a.timeout), 32'd0);
                    check_eq("a_exit_cpu_run", 32'(if_a.cpu_run), 32'd0);
                    check_eq("a_exit_boot_done", 32'(if_a.boot_done), 32'd1);
                end
                16: begin
                    check_eq("a_count_frozen", if_a.cycle_count, 32'd7);
                    check_eq("a_halted_sticky", 32'(if_a.halted), 32'd1);
                end
                default: ;
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
